// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// The master drives the request side; the slave (the adder) drives status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C;

  modport master (
    output start, sub, A, B,
    input  busy, done, S, C
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, S, C
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a registered carry,
// WIDTH/DIGIT cycles per operation, with start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   res_r;
  logic [WIDTH-1:0]   s_r;
  logic               carry_r;
  logic               c_r;
  logic               busy_r;
  logic               done_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [DIGIT:0]     sum_s;
  logic [WIDTH-1:0]   a_shift_s;
  logic [WIDTH-1:0]   b_shift_s;
  logic [WIDTH-1:0]   res_shift_s;
  logic               last_s;
  logic               busy_nxt_s;
  logic               done_nxt_s;

  // Digit adder and shift paths; the new sum digit enters at the top of the result register.
  always_comb begin
    sum_s       = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_r};
    a_shift_s   = a_r >> DIGIT;
    b_shift_s   = b_r >> DIGIT;
    res_shift_s = (res_r >> DIGIT) | (WIDTH'(sum_s[DIGIT-1:0]) << (WIDTH - DIGIT));
    last_s      = (cnt_r == CNT_W'(N - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: start only matters in IDLE, so requests while busy are dropped.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode, registered below so busy/done are glitch-free flops.
  always_comb begin
    busy_nxt_s = (state_nxt_s == RUN);
    done_nxt_s = (state_r == RUN) && last_s;
  end

  // Status output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Operand capture, digit-serial datapath and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      s_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      c_r     <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with sub.
            a_r     <= bus.A;
            b_r     <= bus.sub ? ~bus.B : bus.B;
            carry_r <= bus.sub;
            cnt_r   <= {CNT_W{1'b0}};
            res_r   <= {WIDTH{1'b0}};
          end
        end
        RUN: begin
          a_r     <= a_shift_s;
          b_r     <= b_shift_s;
          res_r   <= res_shift_s;
          carry_r <= sum_s[DIGIT];
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_s) begin
            s_r <= res_shift_s;
            c_r <= sum_s[DIGIT];
          end
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.S    = s_r;
  assign bus.C    = c_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder: 8-bit instances at DIGIT=1 and 4,
// plus exhaustive 4-bit instances at DIGIT=1 and 2.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if81 ();
  serial_adder_if #(.WIDTH(8)) if84 ();
  serial_adder_if #(.WIDTH(4)) if41 ();
  serial_adder_if #(.WIDTH(4)) if42 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_81 (.clk(clk), .rst_n(rst_n), .bus(if81.slave));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_84 (.clk(clk), .rst_n(rst_n), .bus(if84.slave));
  serial_adder #(.WIDTH(4), .DIGIT(1)) u_41 (.clk(clk), .rst_n(rst_n), .bus(if41.slave));
  serial_adder #(.WIDTH(4), .DIGIT(2)) u_42 (.clk(clk), .rst_n(rst_n), .bus(if42.slave));

  // One operation on the 8/1 instance. lat = cycles from acceptance to the done sample,
  // bcnt = cycles busy was seen high, stable = S/C held their old value while busy.
  // If poke >= 0, a stray start with other operands is pulsed at that cycle.
  task automatic op81(input logic [7:0] a, input logic [7:0] b, input logic s, input int poke,
                      output int lat, output int bcnt, output bit stable);
    logic [7:0] s0;
    logic       c0;
    @(negedge clk);
    s0 = if81.S; c0 = if81.C;
    if81.A = a; if81.B = b; if81.sub = s; if81.start = 1'b1;
    @(negedge clk);
    lat = 0; bcnt = 0; stable = 1'b1;
    while (!if81.done && lat < 100) begin
      if (if81.busy) bcnt++;
      if (if81.S !== s0 || if81.C !== c0) stable = 1'b0;
      if (lat == poke) begin
        if81.start = 1'b1; if81.A = 8'hAA; if81.B = 8'h55; if81.sub = 1'b1;
      end else begin
        if81.start = 1'b0; if81.A = 8'($urandom); if81.B = 8'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    if81.start = 1'b0;
  endtask

  task automatic op84(input logic [7:0] a, input logic [7:0] b, input logic s, output int lat);
    @(negedge clk);
    if84.A = a; if84.B = b; if84.sub = s; if84.start = 1'b1;
    @(negedge clk);
    if84.start = 1'b0;
    lat = 0;
    while (!if84.done && lat < 100) begin
      if84.A = 8'($urandom); if84.B = 8'($urandom); if84.sub = 1'($urandom);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op41(input logic [3:0] a, input logic [3:0] b, input logic s, output int lat);
    @(negedge clk);
    if41.A = a; if41.B = b; if41.sub = s; if41.start = 1'b1;
    @(negedge clk);
    if41.start = 1'b0;
    lat = 0;
    while (!if41.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op42(input logic [3:0] a, input logic [3:0] b, input logic s, output int lat);
    @(negedge clk);
    if42.A = a; if42.B = b; if42.sub = s; if42.start = 1'b1;
    @(negedge clk);
    if42.start = 1'b0;
    lat = 0;
    while (!if42.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #2;
    tests++; if (if81.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", if81.busy); end
    tests++; if (if81.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", if81.done); end
    tests++; if (if81.S !== 8'h00) begin fails++; $display("FAIL reset_S: got %h expected 00", if81.S); end
    tests++; if (if81.C !== 1'b0) begin fails++; $display("FAIL reset_C: got %b expected 0", if81.C); end
    tests++; if (if42.S !== 4'h0) begin fails++; $display("FAIL reset_S_42: got %h expected 0", if42.S); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_wrap();
    int lat, bcnt; bit stable;
    op81(8'hFF, 8'h01, 1'b0, -1, lat, bcnt, stable);
    tests++; if (if81.S !== 8'h00) begin fails++; $display("FAIL add_wrap_S: got %h expected 00", if81.S); end
    tests++; if (if81.C !== 1'b1) begin fails++; $display("FAIL add_wrap_C: got %b expected 1", if81.C); end
    tests++; if (lat !== 8) begin fails++; $display("FAIL add_wrap_latency: got %0d expected 8", lat); end
    tests++; if (bcnt !== 8) begin fails++; $display("FAIL add_wrap_busy_cycles: got %0d expected 8", bcnt); end
    tests++; if (if81.busy !== 1'b0) begin fails++; $display("FAIL add_wrap_busy_at_done: got %b expected 0", if81.busy); end
    @(negedge clk);
    tests++; if (if81.done !== 1'b0) begin fails++; $display("FAIL add_wrap_done_width: got %b expected 0", if81.done); end
  endtask

  task automatic test_sub();
    int lat, bcnt; bit stable;
    op81(8'h05, 8'h07, 1'b1, -1, lat, bcnt, stable);
    tests++; if (if81.S !== 8'hFE) begin fails++; $display("FAIL sub_borrow_S: got %h expected fe", if81.S); end
    tests++; if (if81.C !== 1'b0) begin fails++; $display("FAIL sub_borrow_C: got %b expected 0", if81.C); end
    op81(8'h07, 8'h05, 1'b1, -1, lat, bcnt, stable);
    tests++; if (if81.S !== 8'h02) begin fails++; $display("FAIL sub_noborrow_S: got %h expected 02", if81.S); end
    tests++; if (if81.C !== 1'b1) begin fails++; $display("FAIL sub_noborrow_C: got %b expected 1", if81.C); end
    tests++; if (stable !== 1'b1) begin fails++; $display("FAIL sub_result_held: got %b expected 1", stable); end
  endtask

  task automatic test_digit4();
    int lat;
    op84(8'h3C, 8'h4A, 1'b0, lat);
    tests++; if (if84.S !== 8'h86) begin fails++; $display("FAIL digit4_S: got %h expected 86", if84.S); end
    tests++; if (if84.C !== 1'b0) begin fails++; $display("FAIL digit4_C: got %b expected 0", if84.C); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL digit4_latency: got %0d expected 2", lat); end
    op84(8'hF0, 8'h20, 1'b0, lat);
    tests++; if ({if84.C, if84.S} !== 9'h110) begin fails++; $display("FAIL digit4_carry: got %h expected 110", {if84.C, if84.S}); end
  endtask

  task automatic test_back_to_back();
    int last, ndone, guard; bit prev;
    last = -1; ndone = 0; prev = 1'b0;
    @(negedge clk);
    if81.A = 8'h12; if81.B = 8'h34; if81.sub = 1'b0; if81.start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if81.done) begin
        tests++; if (prev) begin fails++; $display("FAIL b2b_done_single: got two-cycle done at %0d expected one", i); end
        if (last >= 0) begin
          tests++; if (i - last !== 9) begin fails++; $display("FAIL b2b_gap: got %0d expected 9", i - last); end
        end
        last = i; ndone++;
      end
      prev = if81.done;
    end
    if81.start = 1'b0;
    tests++; if (ndone !== 4) begin fails++; $display("FAIL b2b_done_count: got %0d expected 4", ndone); end
    guard = 0;
    while (!if81.done && guard < 20) begin @(negedge clk); guard++; end
    tests++; if ({if81.C, if81.S} !== 9'h046) begin fails++; $display("FAIL b2b_result: got %h expected 046", {if81.C, if81.S}); end
  endtask

  task automatic test_start_during_busy();
    int lat, bcnt, extra; bit stable;
    op81(8'h21, 8'h10, 1'b0, 3, lat, bcnt, stable);
    tests++; if ({if81.C, if81.S} !== 9'h031) begin fails++; $display("FAIL busy_start_result: got %h expected 031", {if81.C, if81.S}); end
    tests++; if (lat !== 8) begin fails++; $display("FAIL busy_start_latency: got %0d expected 8", lat); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if81.done || if81.busy) extra++;
    end
    tests++; if (extra !== 0) begin fails++; $display("FAIL busy_start_ignored: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid_op();
    int lat, bcnt, extra; bit stable;
    @(negedge clk);
    if81.A = 8'h05; if81.B = 8'h07; if81.sub = 1'b0; if81.start = 1'b1;
    @(negedge clk);
    if81.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (if81.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", if81.busy); end
    tests++; if (if81.done !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b expected 0", if81.done); end
    tests++; if (if81.S !== 8'h00) begin fails++; $display("FAIL midrst_S: got %h expected 00", if81.S); end
    tests++; if (if81.C !== 1'b0) begin fails++; $display("FAIL midrst_C: got %b expected 0", if81.C); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if81.done || if81.busy) extra++;
    end
    tests++; if (extra !== 0) begin fails++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", extra); end
    op81(8'h05, 8'h07, 1'b0, -1, lat, bcnt, stable);
    tests++; if ({if81.C, if81.S} !== 9'h00C) begin fails++; $display("FAIL midrst_next_op: got %h expected 00c", {if81.C, if81.S}); end
    tests++; if (lat !== 8) begin fails++; $display("FAIL midrst_next_latency: got %0d expected 8", lat); end
  endtask

  task automatic test_exhaustive_w4();
    int lat, exp_s, exp_c;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int s = 0; s < 2; s++) begin
          exp_s = (s != 0) ? ((a - b) & 15) : ((a + b) & 15);
          exp_c = (s != 0) ? ((a >= b) ? 1 : 0) : (((a + b) > 15) ? 1 : 0);
          op41(4'(a), 4'(b), 1'(s), lat);
          tests++; if (if41.S !== 4'(exp_s)) begin fails++; $display("FAIL w4d1_S a=%0d b=%0d sub=%0d: got %0d expected %0d", a, b, s, if41.S, exp_s); end
          tests++; if (if41.C !== 1'(exp_c)) begin fails++; $display("FAIL w4d1_C a=%0d b=%0d sub=%0d: got %b expected %0d", a, b, s, if41.C, exp_c); end
          tests++; if (lat !== 4) begin fails++; $display("FAIL w4d1_latency: got %0d expected 4", lat); end
          op42(4'(a), 4'(b), 1'(s), lat);
          tests++; if (if42.S !== 4'(exp_s)) begin fails++; $display("FAIL w4d2_S a=%0d b=%0d sub=%0d: got %0d expected %0d", a, b, s, if42.S, exp_s); end
          tests++; if (if42.C !== 1'(exp_c)) begin fails++; $display("FAIL w4d2_C a=%0d b=%0d sub=%0d: got %b expected %0d", a, b, s, if42.C, exp_c); end
          tests++; if (lat !== 2) begin fails++; $display("FAIL w4d2_latency: got %0d expected 2", lat); end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if81.start = 1'b0; if81.sub = 1'b0; if81.A = 8'h00; if81.B = 8'h00;
    if84.start = 1'b0; if84.sub = 1'b0; if84.A = 8'h00; if84.B = 8'h00;
    if41.start = 1'b0; if41.sub = 1'b0; if41.A = 4'h0; if41.B = 4'h0;
    if42.start = 1'b0; if42.sub = 1'b0; if42.A = 4'h0; if42.B = 4'h0;
    test_reset();
    test_add_wrap();
    test_sub();
    test_digit4();
    test_back_to_back();
    test_start_during_busy();
    test_reset_mid_op();
    test_exhaustive_w4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
